// File: rtl/power_charge_ctl_if.sv
// ============================================================================
// Module  : power_charge_ctl_if
// Brief   : Shoot-button / power-bar / throw handshake bundle of power_charge_ctl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface power_charge_ctl_if;
  logic       enable;
  logic       current_player;
  logic       button;
  logic       throw_done;
  logic [3:0] power;
  logic       power_player;
  logic       fire;
  logic [3:0] fire_power;
  logic       busy;

  // master: the charge controller itself; slave: its stimulus/consumer side
  modport master (
    input  enable, current_player, button, throw_done,
    output power, power_player, fire, fire_power, busy
  );
  modport slave (
    output enable, current_player, button, throw_done,
    input  power, power_player, fire, fire_power, busy
  );
endinterface

`default_nettype wire

// File: rtl/power_charge_ctl.sv
// ============================================================================
// Module  : power_charge_ctl
// Brief   : Shoot-button charge meter; POWER_PINGPONG_EN makes power oscillate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module power_charge_ctl #(
  parameter int TICK_CYCLES = 3_000_000,
  parameter int MAX_POWER   = 15
) (
  input  logic               clk60MHz,
  input  logic               rst_n,
  power_charge_ctl_if.master bus
);

  localparam int               c_TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
  localparam logic [3:0]       c_MAX       = 4'(MAX_POWER);
  localparam logic             c_PLAYER_1  = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_TICK_W-1:0] r_tick, w_tick_nxt;
  logic [3:0]          r_power, w_power_nxt;
  logic [3:0]          r_fire_power, w_fire_power_nxt;
  logic                r_power_player, w_player_nxt;
  logic                r_fire, w_fire_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_tick_last;
`ifdef POWER_PINGPONG_EN
  logic                r_dir_up, w_dir_up_nxt;
`endif

  logic r_sync1, r_btn_s, r_btn_d;
  logic w_press;

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_btn_d <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_btn_s <= r_sync1;
      r_btn_d <= r_btn_s;
    end
  end

  assign w_press = r_btn_s & ~r_btn_d;

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_tick         <= '0;
      r_power        <= '0;
      r_fire_power   <= '0;
      r_power_player <= c_PLAYER_1;
      r_fire         <= 1'b0;
      r_busy         <= 1'b0;
`ifdef POWER_PINGPONG_EN
      r_dir_up       <= 1'b1;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_tick         <= w_tick_nxt;
      r_power        <= w_power_nxt;
      r_fire_power   <= w_fire_power_nxt;
      r_power_player <= w_player_nxt;
      r_fire         <= w_fire_nxt;
      r_busy         <= w_busy_nxt;
`ifdef POWER_PINGPONG_EN
      r_dir_up       <= w_dir_up_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tick_nxt       = r_tick;
    w_power_nxt      = r_power;
    w_fire_power_nxt = r_fire_power;
    w_player_nxt     = r_power_player;
`ifdef POWER_PINGPONG_EN
    w_dir_up_nxt     = r_dir_up;
`endif
    w_tick_last      = (r_tick == c_TICK_LAST);

    case (r_state)
      IDLE: begin
        w_power_nxt = '0;
        if (bus.enable && w_press) begin
          w_state_nxt  = CHARGE;
          w_tick_nxt   = '0;
          w_player_nxt = bus.current_player;
`ifdef POWER_PINGPONG_EN
          w_dir_up_nxt = 1'b1;
`endif
        end
      end
      CHARGE: begin
        // Abort beats release; release beats a coincident tick.
        if (!bus.enable) begin
          w_state_nxt = IDLE;
          w_power_nxt = '0;
        end else if (!r_btn_s) begin
          w_state_nxt      = FIRE;
          w_fire_power_nxt = r_power;
        end else begin
          w_tick_nxt = w_tick_last ? '0 : r_tick + c_TICK_W'(1);
          if (w_tick_last) begin
`ifdef POWER_PINGPONG_EN
            if (r_dir_up) begin
              if (r_power >= c_MAX) begin
                w_dir_up_nxt = 1'b0;
                w_power_nxt  = c_MAX - 4'd1;
              end else begin
                w_power_nxt  = r_power + 4'd1;
              end
            end else begin
              if (r_power == 4'd0) begin
                w_dir_up_nxt = 1'b1;
                w_power_nxt  = 4'd1;
              end else begin
                w_power_nxt  = r_power - 4'd1;
              end
            end
`else
            if (r_power < c_MAX) begin
              w_power_nxt = r_power + 4'd1;
            end
`endif
          end
        end
      end
      FIRE: begin
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.throw_done) begin
          w_state_nxt = IDLE;
          w_power_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_power_nxt = '0;
      end
    endcase

    w_fire_nxt = (w_state_nxt == FIRE);
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.power        = r_power;
  assign bus.power_player = r_power_player;
  assign bus.fire         = r_fire;
  assign bus.fire_power   = r_fire_power;
  assign bus.busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_power_charge_ctl.sv
// ============================================================================
// Module  : tb_power_charge_ctl
// Brief   : Directed self-checking bench for power_charge_ctl (TICK_CYCLES=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_power_charge_ctl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   fire_count = 0;

  power_charge_ctl_if bus();

  power_charge_ctl #(
    .TICK_CYCLES(4),
    .MAX_POWER  (15)
  ) dut (
    .clk60MHz(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fire === 1'b1) fire_count++;
  end

  // Inputs change and outputs are checked on the falling edge.
  task automatic test_reset();
    rst_n = 1'b0;
    bus.button = 1'b1;
    bus.enable = 1'b0;
    bus.current_player = 1'b0;
    bus.throw_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.power !== 4'd0) begin errors++; $display("FAIL reset_power got %0d exp 0", bus.power); end
    checks++; if (bus.fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %0b exp 0", bus.fire); end
    checks++; if (bus.fire_power !== 4'd0) begin errors++; $display("FAIL reset_fire_power got %0d exp 0", bus.fire_power); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.power_player !== 1'b0) begin errors++; $display("FAIL reset_player got %0b exp 0", bus.power_player); end
    bus.button = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b exp 0", bus.busy); end
  endtask

  task automatic test_partial_charge();
    int fc0;
    fc0 = fire_count;
    bus.enable = 1'b1;
    bus.current_player = 1'b1;
    bus.button = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      @(negedge clk);
      if (i == 2) begin checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL partial_busy_pre got %0b exp 0", bus.busy); end end
      if (i == 3) begin checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL partial_busy got %0b exp 1", bus.busy); end end
      if (i == 6) begin checks++; if (bus.power !== 4'd0) begin errors++; $display("FAIL partial_lat0 got %0d exp 0", bus.power); end end
      if (i == 7) begin checks++; if (bus.power !== 4'd1) begin errors++; $display("FAIL partial_lat1 got %0d exp 1", bus.power); end end
    end
    bus.button = 1'b0;
    for (int i = 39; i <= 42; i++) begin
      @(negedge clk);
      if (i == 40) begin checks++; if (bus.fire !== 1'b0) begin errors++; $display("FAIL partial_fire_early got %0b exp 0", bus.fire); end end
      if (i == 41) begin
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL partial_fire got %0b exp 1", bus.fire); end
        checks++; if (bus.fire_power !== 4'd9) begin errors++; $display("FAIL partial_fire_power got %0d exp 9", bus.fire_power); end
        checks++; if (bus.power_player !== 1'b1) begin errors++; $display("FAIL partial_player got %0b exp 1", bus.power_player); end
      end
      if (i == 42) begin
        checks++; if (bus.fire !== 1'b0) begin errors++; $display("FAIL partial_fire_width got %0b exp 0", bus.fire); end
        checks++; if (bus.power !== 4'd9) begin errors++; $display("FAIL partial_hold got %0d exp 9", bus.power); end
      end
    end
    bus.throw_done = 1'b1;
    @(negedge clk);
    bus.throw_done = 1'b0;
    checks++; if (bus.power !== 4'd0) begin errors++; $display("FAIL partial_done_power got %0d exp 0", bus.power); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL partial_done_busy got %0b exp 0", bus.busy); end
    checks++; if (fire_count !== fc0 + 1) begin errors++; $display("FAIL partial_fire_count got %0d exp %0d", fire_count, fc0 + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [3:0] exp67, exp100;
`ifdef POWER_PINGPONG_EN
    exp67 = 4'd14; exp100 = 4'd6;
`else
    exp67 = 4'd15; exp100 = 4'd15;
`endif
    bus.enable = 1'b1;
    bus.current_player = 1'b0;
    bus.button = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 62) begin checks++; if (bus.power !== 4'd14) begin errors++; $display("FAIL sat_62 got %0d exp 14", bus.power); end end
      if (i == 63) begin checks++; if (bus.power !== 4'd15) begin errors++; $display("FAIL sat_63 got %0d exp 15", bus.power); end end
      if (i == 67) begin checks++; if (bus.power !== exp67) begin errors++; $display("FAIL sat_67 got %0d exp %0d", bus.power, exp67); end end
      if (i == 100) begin checks++; if (bus.power !== exp100) begin errors++; $display("FAIL sat_100 got %0d exp %0d", bus.power, exp100); end end
    end
    bus.button = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL sat_fire got %0b exp 1", bus.fire); end
    checks++; if (bus.fire_power !== exp100) begin errors++; $display("FAIL sat_fire_power got %0d exp %0d", bus.fire_power, exp100); end
    checks++; if (bus.power_player !== 1'b0) begin errors++; $display("FAIL sat_player got %0b exp 0", bus.power_player); end
    @(negedge clk);
    bus.throw_done = 1'b1;
    @(negedge clk);
    bus.throw_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sat_done_busy got %0b exp 0", bus.busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_release_on_tick();
    bus.enable = 1'b1;
    bus.current_player = 1'b1;
    bus.button = 1'b1;
    repeat (24) @(negedge clk);
    bus.button = 1'b0;
    for (int i = 25; i <= 28; i++) begin
      @(negedge clk);
      if (i == 26) begin checks++; if (bus.power !== 4'd5) begin errors++; $display("FAIL tick_pre got %0d exp 5", bus.power); end end
      if (i == 27) begin
        checks++; if (bus.fire !== 1'b1) begin errors++; $display("FAIL tick_fire got %0b exp 1", bus.fire); end
        checks++; if (bus.fire_power !== 4'd5) begin errors++; $display("FAIL tick_fire_power got %0d exp 5", bus.fire_power); end
      end
      if (i == 28) begin checks++; if (bus.power !== 4'd5) begin errors++; $display("FAIL tick_power_hold got %0d exp 5", bus.power); end end
    end
    bus.throw_done = 1'b1;
    @(negedge clk);
    bus.throw_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int fc0;
    fc0 = fire_count;
    bus.enable = 1'b1;
    bus.button = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin checks++; if (bus.power !== 4'd3) begin errors++; $display("FAIL abort_pre got %0d exp 3", bus.power); end end
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.power !== 4'd0) begin errors++; $display("FAIL abort_power got %0d exp 0", bus.power); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", bus.busy); end
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_rearm got %0b exp 0", bus.busy); end
    checks++; if (fire_count !== fc0) begin errors++; $display("FAIL abort_fire_count got %0d exp %0d", fire_count, fc0); end
    bus.button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ignore();
    int fc0;
    fc0 = fire_count;
    bus.enable = 1'b0;
    bus.button = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_disabled_busy got %0b exp 0", bus.busy); end
    bus.button = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    bus.button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) bus.throw_done = 1'b1;
      if (i == 6) bus.throw_done = 1'b0;
      if (i == 8) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_done_busy got %0b exp 1", bus.busy); end
        checks++; if (bus.power !== 4'd1) begin errors++; $display("FAIL ign_done_power got %0d exp 1", bus.power); end
      end
    end
    bus.button = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.fire_power !== 4'd2) begin errors++; $display("FAIL ign_fire_power got %0d exp 2", bus.fire_power); end
    for (int j = 0; j < 6; j++) begin
      bus.button = ~bus.button;
      repeat (3) @(negedge clk);
    end
    bus.button = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_wait_busy got %0b exp 1", bus.busy); end
    checks++; if (fire_count !== fc0 + 1) begin errors++; $display("FAIL ign_fire_count got %0d exp %0d", fire_count, fc0 + 1); end
    bus.throw_done = 1'b1;
    @(negedge clk);
    bus.throw_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_done got %0b exp 0", bus.busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int fc0;
    fc0 = fire_count;
    bus.enable = 1'b1;
    bus.button = 1'b1;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.power !== 4'd0) begin errors++; $display("FAIL rst_abort_power got %0d exp 0", bus.power); end
    bus.button = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (fire_count !== fc0) begin errors++; $display("FAIL rst_abort_fire got %0d exp %0d", fire_count, fc0); end
  endtask

  initial begin
    test_reset();
    test_partial_charge();
    test_saturation();
    test_release_on_tick();
    test_abort();
    test_ignore();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/power_charge_ctl.md
Name: power_charge_ctl

Overview:
- Producer of the 4-bit `power` value consumed by the power-bar renderer; the renderer is its display sink.
- Turns the active player's shoot button into a charging power level: starts on press, rises at a fixed tick rate while held, freezes on release.
- On release it issues a one-cycle `fire` pulse with the latched power and shooter, then holds the bar until the throw logic reports completion.
- Sits in the game-control domain on clk60MHz, between the input decoder (keyboard/mouse) and the throw/trajectory block.

Parameters:
- TICK_CYCLES, 3_000_000, clk60MHz cycles per power step (50 ms at 60 MHz). Must be ≥ 2.
- MAX_POWER, 15, saturation value of `power`. Must be ≤ 15.

Ports:
- clk60MHz  in  1  system clock, 60 MHz
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  turn is live; charging is permitted only while high
- current_player  in  1  player whose turn it is (PLAYER_1 / PLAYER_2 encoding from variable_pkg)
- button  in  1  raw, asynchronous shoot button, high = pressed
- throw_done  in  1  single-cycle pulse from the throw logic: projectile resolved
- power  out  4  live power level for the bar renderer
- power_player  out  1  player the bar belongs to; drive the renderer's current_player from this
- fire  out  1  one-cycle launch strobe
- fire_power  out  4  power latched at release; valid when `fire` is high, then held
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous on rst_n low.
  - State = IDLE; tick counter = 0; sync flops = 0.
  - power, fire, fire_power, busy = 0; power_player = PLAYER_1.
  - Reset mid-operation aborts everything with no `fire`.
- All outputs are registered.
- Input synchronisation:
  - `button` passes through a 2-FF synchroniser to give btn_s, plus a delayed copy btn_d.
  - press = btn_s & ~btn_d.
  - All FSM decisions use btn_s/press, never the raw input.
- FSM states: IDLE, CHARGE, FIRE, WAIT_DONE.
- IDLE:
  - power = 0.
  - On enable & press: go to CHARGE, clear the tick counter, latch power_player = current_player.
  - A press while enable is low is ignored. Going low then high again does not re-arm without a new press edge.
- CHARGE:
  - The tick counter runs 0..TICK_CYCLES-1 and wraps to 0.
  - On wrap, power increments by 1, saturating at MAX_POWER. Once saturated it holds; no wrap to 0.
  - When btn_s = 0: go to FIRE and latch fire_power = the current power.
  - Release and tick terminal in the same cycle: release wins, no increment, and fire_power takes the pre-increment value.
  - When enable = 0 (takes priority over release): go to IDLE, power = 0, no `fire`.
  - Latency: `power` first reads 1 exactly TICK_CYCLES cycles after entering CHARGE.
- FIRE:
  - `fire` = 1 for exactly this one cycle, then go unconditionally to WAIT_DONE.
  - power and fire_power hold.
  - End-to-end: `fire` rises 3 clocks after the raw button falls, assuming button was sampled low on edge 0.
- WAIT_DONE:
  - power, fire_power and power_player hold.
  - Button activity is ignored.
  - On throw_done: go to IDLE, power = 0.
  - A throw_done arriving in any other state is ignored.
- power_player: changes only on IDLE→CHARGE, so a current_player change mid-turn never moves the bar.
- busy = (state != IDLE).

Optional Feature:
- Macro: POWER_PINGPONG_EN.
- Defined: in CHARGE, power oscillates instead of saturating.
  - A direction flag starts "up" on entry to CHARGE.
  - Counting up, the tick at power == MAX_POWER flips the flag and steps down to MAX_POWER-1.
  - Counting down, the tick at power == 0 flips it and steps up to 1.
  - Release semantics are unchanged.
- Undefined: saturate at MAX_POWER as above; no direction flag is synthesised.

Test Plan (TICK_CYCLES = 4, MAX_POWER = 15):
- Reset: rst_n low for 3 cycles with button high → all outputs 0, busy 0. Release rst_n with button low → stays IDLE.
- Partial charge: enable = 1, current_player = PLAYER_2, press, release so that 9 tick wraps occurred → power = 9, one-cycle fire with fire_power = 9, power_player = PLAYER_2. Then throw_done → power 0, busy 0.
- Saturation: hold button 100 cycles in CHARGE → power reaches 15 at cycle 60 and stays 15. On release, fire_power = 15. With POWER_PINGPONG_EN defined, power reads 15 after 60 cycles and 14 after 64.
- Release on tick: release aligned so btn_s falls on a terminal-count cycle with power = 5 → fire_power = 5, power stays 5.
- Abort: drop enable at power = 3 in CHARGE → power 0, IDLE, no fire pulse.
- Ignore: press with enable = 0 → nothing. Button toggling in WAIT_DONE → no second fire. throw_done while in CHARGE → no state change.
